// File: rtl/broad_phase_scheduler.sv
// broad_phase_scheduler: walks every object pair (i<j), AABB-tests it and issues overlapping pairs to Collide
// Ports:
//   clk, rst                                   clock; asynchronous active-low reset
//   start, abort                               scan control from the physics-step controller
//   obj_idx -> obj_active, obj_min_*, obj_max_* object store read port, data one cycle after address
//   np_start, np_A_nth, np_B_nth <- np_done     Collide job launch and completion
//   busy, scan_done, pairs_tested, pairs_hit    scan status and per-scan statistics
module broad_phase_scheduler #(
   parameter int N_OBJ = 8,
   parameter int W     = 19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   output logic [3:0]   obj_idx,
   input  logic         obj_active,
   input  logic [W-1:0] obj_min_x,
   input  logic [W-1:0] obj_min_y,
   input  logic [W-1:0] obj_max_x,
   input  logic [W-1:0] obj_max_y,
   output logic         np_start,
   output logic [3:0]   np_A_nth,
   output logic [3:0]   np_B_nth,
   input  logic         np_done,
   output logic         busy,
   output logic         scan_done,
   output logic [7:0]   pairs_tested,
   output logic [7:0]   pairs_hit
);
   typedef enum logic [3:0] {IDLE, FETCH_A, LATCH_A, FETCH_B, CMP, ISSUE, WAIT, NEXT, FIN} state_t;
   localparam logic [3:0] J_LAST = 4'(N_OBJ - 1);
   localparam logic [3:0] I_LAST = 4'(N_OBJ - 2);
   state_t state, nxt;
   logic [3:0] i, j, i_nxt, j_nxt;
   logic a_active, abort_pend, overlap;
   logic [W-1:0] a_min_x, a_min_y, a_max_x, a_max_y;
   // B box is consumed straight off the store read port during CMP
   assign overlap = a_active & obj_active
      & ($signed(a_min_x) <= $signed(obj_max_x)) & ($signed(obj_min_x) <= $signed(a_max_x))
      & ($signed(a_min_y) <= $signed(obj_max_y)) & ($signed(obj_min_y) <= $signed(a_max_y));
   always_comb begin
      nxt   = state;
      i_nxt = i;
      j_nxt = j;
      case (state)
         IDLE:    if (start) begin nxt = FETCH_A; i_nxt = 4'd0; j_nxt = 4'd1; end
         FETCH_A: nxt = LATCH_A;
         LATCH_A: nxt = CMP;
         FETCH_B: nxt = CMP;
         CMP:     nxt = overlap ? ISSUE : NEXT;
         ISSUE:   nxt = WAIT;
         WAIT:    if (np_done) nxt = (abort || abort_pend) ? IDLE : NEXT;
         NEXT:
            if (j < J_LAST) begin
               j_nxt = j + 4'd1;
               nxt   = FETCH_B;
            end else if (i < I_LAST) begin
               i_nxt = i + 4'd1;
               j_nxt = i + 4'd2;
               nxt   = FETCH_A;
            end else nxt = FIN;
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // an outstanding Collide job must finish before the scan can be dropped
      if (abort && state != WAIT) begin
         nxt   = IDLE;
         i_nxt = i;
         j_nxt = j;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         i            <= 4'd0;
         j            <= 4'd1;
         obj_idx      <= 4'd0;
         np_start     <= 1'b0;
         np_A_nth     <= 4'd0;
         np_B_nth     <= 4'd0;
         busy         <= 1'b0;
         scan_done    <= 1'b0;
         pairs_tested <= 8'd0;
         pairs_hit    <= 8'd0;
         abort_pend   <= 1'b0;
         a_active     <= 1'b0;
         a_min_x      <= '0;
         a_min_y      <= '0;
         a_max_x      <= '0;
         a_max_y      <= '0;
      end else begin
         i          <= i_nxt;
         j          <= j_nxt;
         // outputs are registered from the next state so they line up with it
         obj_idx    <= nxt == FETCH_A ? i_nxt : (nxt == LATCH_A || nxt == FETCH_B) ? j_nxt : obj_idx;
         np_start   <= nxt == ISSUE;
         busy       <= nxt != IDLE;
         scan_done  <= nxt == FIN;
         abort_pend <= state == WAIT && nxt == WAIT && (abort || abort_pend);
         if (nxt == ISSUE) begin
            np_A_nth  <= i;
            np_B_nth  <= j;
            pairs_hit <= pairs_hit + {7'd0, pairs_hit != 8'hFF};
         end
         if (state == LATCH_A) begin
            a_active <= obj_active;
            a_min_x  <= obj_min_x;
            a_min_y  <= obj_min_y;
            a_max_x  <= obj_max_x;
            a_max_y  <= obj_max_y;
         end
         if (state == CMP && nxt != IDLE) pairs_tested <= pairs_tested + {7'd0, pairs_tested != 8'hFF};
         if (state == IDLE && nxt == FETCH_A) begin
            pairs_tested <= 8'd0;
            pairs_hit    <= 8'd0;
         end
      end
endmodule

// File: tb/tb_broad_phase_scheduler.sv
// tb_broad_phase_scheduler: scoreboard bench for broad_phase_scheduler at N_OBJ = 2, 3 and 4
module tb_broad_phase_scheduler;
   logic clk = 1'b0, rst = 1'b0, abort = 1'b0, np_done = 1'b0;
   logic [2:0] start = 3'b000;
   logic [2:0] np_start, busy, scan_done, rd_act;
   logic [3:0] obj_idx [3], np_a [3], np_b [3];
   logic [7:0] tested [3], hit [3];
   logic [18:0] rd_mnx [3], rd_mny [3], rd_mxx [3], rd_mxy [3];
   logic act [16];
   logic signed [18:0] mnx [16], mny [16], mxx [16], mxy [16];
   logic [7:0] exp_q [$];
   int tests = 0, failed = 0;

   always #5 clk = ~clk;

   // instance g scans g+2 objects; all share one object store
   for (genvar g = 0; g < 3; g++) begin : g_dut
      broad_phase_scheduler #(.N_OBJ(g + 2), .W(19)) dut (
         .clk(clk), .rst(rst), .start(start[g]), .abort(abort), .obj_idx(obj_idx[g]),
         .obj_active(rd_act[g]), .obj_min_x(rd_mnx[g]), .obj_min_y(rd_mny[g]),
         .obj_max_x(rd_mxx[g]), .obj_max_y(rd_mxy[g]), .np_start(np_start[g]),
         .np_A_nth(np_a[g]), .np_B_nth(np_b[g]), .np_done(np_done), .busy(busy[g]),
         .scan_done(scan_done[g]), .pairs_tested(tested[g]), .pairs_hit(hit[g]));
   end

   always @(posedge clk)
      for (int k = 0; k < 3; k++) begin
         rd_act[k] <= act[obj_idx[k]];
         rd_mnx[k] <= mnx[obj_idx[k]];
         rd_mny[k] <= mny[obj_idx[k]];
         rd_mxx[k] <= mxx[obj_idx[k]];
         rd_mxy[k] <= mxy[obj_idx[k]];
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_box(input int k, input logic a, input int x0, input int x1, input int y0, input int y1);
      act[k] = a;
      mnx[k] = 19'(x0 * 256);
      mxx[k] = 19'(x1 * 256);
      mny[k] = 19'(y0 * 256);
      mxy[k] = 19'(y1 * 256);
   endtask

   function automatic bit ovl(input int a, input int b);
      return act[a] && act[b] && mnx[a] <= mxx[b] && mnx[b] <= mxx[a] && mny[a] <= mxy[b] && mny[b] <= mxy[a];
   endfunction

   task automatic wait_issue(input int k);
      for (int c = 0; c < 50 && !np_start[k]; c++) begin
         @(posedge clk);
         #1;
      end
      chk("issue_seen", 32'(np_start[k]), 1);
   endtask

   // runs one full scan on instance k; Collide answers dly cycles after each np_start
   task automatic run_scan(input int k, input int dly, input int exp_cyc);
      int n, cd, cyc, et, eh;
      logic [7:0] last;
      n = k + 2; et = 0; eh = 0; cd = 0; cyc = 0; last = 8'd0;
      for (int a = 0; a < n - 1; a++)
         for (int b = a + 1; b < n; b++) begin
            et++;
            if (ovl(a, b)) begin
               eh++;
               exp_q.push_back({4'(a), 4'(b)});
            end
         end
      start[k] = 1'b1;
      @(posedge clk);
      #1 start[k] = 1'b0;
      while (cyc < 2000) begin
         @(posedge clk);
         #1 cyc++;
         if (cyc == 1) chk("busy_run", 32'(busy[k]), 1);
         np_done = (cd == 1);
         if (cd == 1) chk("hold_pair", {24'd0, np_a[k], np_b[k]}, {24'd0, last});
         if (cd > 0) cd--;
         if (np_start[k]) begin
            if (exp_q.size() == 0) chk("spurious_issue", {24'd0, np_a[k], np_b[k]}, 32'hFFFF_FFFF);
            else begin
               last = exp_q.pop_front();
               chk("pair", {24'd0, np_a[k], np_b[k]}, {24'd0, last});
               cd = dly;
            end
         end
         if (scan_done[k]) break;
      end
      np_done = 1'b0;
      chk("scan_done_seen", 32'(scan_done[k]), 1);
      if (exp_cyc > 0) chk("scan_cycles", cyc, exp_cyc);
      chk("tested", 32'(tested[k]), et);
      chk("hit", 32'(hit[k]), eh);
      chk("queue_empty", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk);
      #1 chk("busy_after", 32'(busy[k]), 0);
   endtask

   initial begin
      bit seen;
      for (int k = 0; k < 16; k++) set_box(k, 1'b0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy[2]), 0);
      chk("rst_np_start", 32'(np_start[2]), 0);
      chk("rst_scan_done", 32'(scan_done[2]), 0);
      chk("rst_idx", 32'(obj_idx[2]), 0);
      chk("rst_pair", {24'd0, np_a[2], np_b[2]}, 0);
      chk("rst_cnt", {16'd0, tested[2], hit[2]}, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      // two objects, one overlapping pair
      set_box(0, 1'b1, 50, 150, 50, 150);
      set_box(1, 1'b1, 100, 200, 0, 100);
      run_scan(0, 5, 0);
      chk("basic_hit", 32'(hit[0]), 1);
      // four disjoint boxes: scan length
      for (int k = 0; k < 4; k++) set_box(k, 1'b1, 300 * k, 300 * k + 100, 0, 100);
      run_scan(2, 3, 21);
      // touching edges
      set_box(0, 1'b1, 0, 100, 0, 100);
      set_box(1, 1'b1, 100, 200, 0, 100);
      run_scan(0, 2, 0);
      chk("touch_hit", 32'(hit[0]), 1);
      // negative coordinates
      set_box(0, 1'b1, -50, -10, 0, 100);
      set_box(1, 1'b1, -9, 20, 0, 100);
      run_scan(0, 2, 0);
      chk("sign_nohit", 32'(hit[0]), 0);
      set_box(1, 1'b1, -20, 20, 0, 100);
      run_scan(0, 2, 0);
      chk("sign_hit", 32'(hit[0]), 1);
      // inactive object masked out
      for (int k = 0; k < 4; k++) set_box(k, 1'b1, 0, 100, 0, 100);
      act[1] = 1'b0;
      run_scan(1, 2, 0);
      chk("mask_hit", 32'(hit[1]), 1);
      // every pair overlaps
      act[1] = 1'b1;
      run_scan(2, 1, 0);
      // abort held through WAIT of pair (0,1), plus a start while busy
      start[2] = 1'b1;
      @(posedge clk);
      #1 start[2] = 1'b0;
      wait_issue(2);
      chk("ab_pair", {24'd0, np_a[2], np_b[2]}, 32'h01);
      @(posedge clk);
      #1 abort = 1'b1;
      start[2] = 1'b1;
      @(posedge clk);
      #1 start[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("ab_defer", 32'(busy[2]), 1);
      np_done = 1'b1;
      @(posedge clk);
      #1 np_done = 1'b0;
      chk("ab_idle", 32'(busy[2]), 0);
      abort = 1'b0;
      chk("ab_tested", 32'(tested[2]), 1);
      chk("ab_hit", 32'(hit[2]), 1);
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1 if (np_start[2] || scan_done[2] || busy[2]) seen = 1'b1;
      end
      chk("ab_quiet", 32'(seen), 0);
      // reset in the middle of WAIT
      start[2] = 1'b1;
      @(posedge clk);
      #1 start[2] = 1'b0;
      wait_issue(2);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mr_busy", 32'(busy[2]), 0);
      chk("mr_np_start", 32'(np_start[2]), 0);
      chk("mr_pair", {24'd0, np_a[2], np_b[2]}, 0);
      chk("mr_idx", 32'(obj_idx[2]), 0);
      chk("mr_cnt", {16'd0, tested[2], hit[2]}, 0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1 np_done = 1'b1;
      @(posedge clk);
      #1 np_done = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1 if (np_start[2] || busy[2] || scan_done[2]) seen = 1'b1;
      end
      chk("mr_quiet", 32'(seen), 0);
      run_scan(2, 2, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
      $fatal(1);
   end
endmodule
